// File: rtl/acc_writeback_ctrl.sv
// acc_writeback_ctrl: streams N=MATRIX_SIZE^2 accumulators into DPRAM.
// Optional macro ACC_WB_SATURATE_EN selects saturating narrowing; otherwise the data wraps.
`default_nettype none

module acc_writeback_ctrl #(
   parameter int DATA_WIDTH     = 8,
   parameter int MATRIX_SIZE    = 8,
   parameter int ACC_WIDTH      = 32,
   parameter int ACC_ADDR_WIDTH = $clog2(MATRIX_SIZE*MATRIX_SIZE),
   parameter int DP_ADDR_WIDTH  = 10,
   parameter int SHIFT          = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      abort,
   input  logic [DP_ADDR_WIDTH-1:0]  base_addr,
   output logic [ACC_ADDR_WIDTH-1:0] addr_acc,
   input  logic [ACC_WIDTH-1:0]      acc_out,
   output logic                      wb_we,
   output logic [DP_ADDR_WIDTH-1:0]  wb_addr,
   output logic [DATA_WIDTH-1:0]     wb_din,
   output logic                      busy,
   output logic                      done,
   output logic [1:0]                state_out
);

   localparam int N = MATRIX_SIZE * MATRIX_SIZE;
   localparam logic [ACC_ADDR_WIDTH-1:0] LAST_IDX = ACC_ADDR_WIDTH'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_READ   = 2'd1,
      S_DRAIN  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t                      state_q, state_d;
   logic [ACC_ADDR_WIDTH-1:0]   idx_q, idx_d;
   logic [DP_ADDR_WIDTH-1:0]    base_q, base_d;
   logic                        we_q, we_d;
   logic [DP_ADDR_WIDTH-1:0]    waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0]       narrow;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         base_q  <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         base_q  <= base_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
      end
   end

   // The write for index k is staged one cycle behind addr_acc=k, matching the
   // one-cycle read latency of the accumulator array.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      base_d  = base_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               base_d  = base_addr;
               idx_d   = '0;
               state_d = S_READ;
            end
         end
         S_READ: begin
            if (abort) begin
               idx_d   = '0;
               state_d = S_IDLE;
            end else begin
               we_d    = 1'b1;
               waddr_d = base_q + DP_ADDR_WIDTH'(idx_q);
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = S_DRAIN;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            state_d = abort ? S_IDLE : S_FINISH;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

`ifdef ACC_WB_SATURATE_EN
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic signed [ACC_WIDTH-1:0] shifted;

   always_comb begin
      shifted = $signed(acc_out) >>> SHIFT;
      narrow  = shifted[DATA_WIDTH-1:0];
      if (shifted > SAT_MAX) begin
         narrow = SAT_MAX[DATA_WIDTH-1:0];
      end else if (shifted < SAT_MIN) begin
         narrow = SAT_MIN[DATA_WIDTH-1:0];
      end
   end
`else
   always_comb begin
      narrow = DATA_WIDTH'($signed(acc_out) >>> SHIFT);
   end
`endif

   assign addr_acc  = (state_q == S_READ) ? idx_q : '0;
   assign wb_we     = we_q;
   assign wb_addr   = we_q ? waddr_q : '0;
   assign wb_din    = we_q ? narrow : '0;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_FINISH);
   assign state_out = state_q;

endmodule

`default_nettype wire

// File: tb/tb_acc_writeback_ctrl.sv
// Directed self-checking bench for acc_writeback_ctrl (default parameters, N=64).
`default_nettype none

module tb_acc_writeback_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [9:0]  base_addr = '0;
   logic [5:0]  addr_acc;
   logic [31:0] acc_out = '0;
   logic        wb_we;
   logic [9:0]  wb_addr;
   logic [7:0]  wb_din;
   logic        busy;
   logic        done;
   logic [1:0]  state_out;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] acc_mem [0:63];
   logic [9:0]  wr_addr [0:127];
   logic [7:0]  wr_data [0:127];
   int          wr_cyc  [0:127];
   logic        busy_log  [0:80];
   logic [1:0]  state_log [0:80];
   int          nw, done_cnt, done_cyc;
   logic [31:0] snap;

   acc_writeback_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
      .addr_acc(addr_acc), .acc_out(acc_out), .wb_we(wb_we), .wb_addr(wb_addr),
      .wb_din(wb_din), .busy(busy), .done(done), .state_out(state_out)
   );

   always #5 clk = ~clk;

   // Accumulator array model: one-cycle read latency.
   always @(posedge clk) acc_out <= acc_mem[addr_acc];

   // Launches a pass and observes cycles 1..72 after the accepting edge.
   // Hooks fire in READ when addr_acc equals the given index (-1 disables).
   task automatic run_pass(input logic [9:0] base, input int ab_idx, input int st_idx, input int rs_idx);
      @(negedge clk);
      base_addr = base;
      start = 1'b1;
      @(posedge clk);
      nw = 0; done_cnt = 0; done_cyc = -1; snap = '1;
      for (int n = 1; n <= 72; n++) begin
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         busy_log[n]  = busy;
         state_log[n] = state_out;
         if (wb_we) begin
            wr_addr[nw] = wb_addr;
            wr_data[nw] = wb_din;
            wr_cyc[nw]  = n;
            nw++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = n;
         end
         if (state_out == 2'd1 && int'(addr_acc) == ab_idx) abort = 1'b1;
         if (state_out == 2'd1 && int'(addr_acc) == st_idx) start = 1'b1;
         if (state_out == 2'd1 && int'(addr_acc) == rs_idx) begin
            rst = 1'b1;
            #1;
            snap = {9'd0, addr_acc, wb_we, wb_addr, wb_din, busy, done, state_out};
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (state_out !== 2'd0) $display("FAIL reset_state got=%0d want=0", state_out); else n_pass++;
      n_checks++; if ({busy, done, wb_we} !== 3'b000) $display("FAIL reset_flags got=%b want=000", {busy, done, wb_we}); else n_pass++;
      n_checks++; if (addr_acc !== 6'd0) $display("FAIL reset_addr_acc got=%0d want=0", addr_acc); else n_pass++;
      n_checks++; if ({wb_addr, wb_din} !== 18'd0) $display("FAIL reset_wb got=%h want=0", {wb_addr, wb_din}); else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_full_pass();
      for (int k = 0; k < 64; k++) acc_mem[k] = 32'(3 * k);
      run_pass(10'h100, -1, -1, -1);
      n_checks++; if (nw !== 64) $display("FAIL full_count got=%0d want=64", nw); else n_pass++;
      for (int k = 0; k < nw && k < 64; k++) begin
         n_checks++; if (wr_addr[k] !== 10'(10'h100 + k)) $display("FAIL full_addr[%0d] got=%h want=%h", k, wr_addr[k], 10'(10'h100 + k)); else n_pass++;
         n_checks++; if (wr_data[k] !== 8'(3 * k)) $display("FAIL full_data[%0d] got=%h want=%h", k, wr_data[k], 8'(3 * k)); else n_pass++;
         n_checks++; if (wr_cyc[k] !== k + 2) $display("FAIL full_cycle[%0d] got=%0d want=%0d", k, wr_cyc[k], k + 2); else n_pass++;
      end
      n_checks++; if (done_cnt !== 1 || done_cyc !== 66) $display("FAIL full_done got=%0d@%0d want=1@66", done_cnt, done_cyc); else n_pass++;
      n_checks++; if ({busy_log[1], busy_log[66], busy_log[67]} !== 3'b110) $display("FAIL full_busy got=%b want=110", {busy_log[1], busy_log[66], busy_log[67]}); else n_pass++;
      n_checks++; if ({state_log[1], state_log[64], state_log[65], state_log[66], state_log[67]} !== 10'b01_01_10_11_00)
         $display("FAIL full_states got=%b want=0101101100", {state_log[1], state_log[64], state_log[65], state_log[66], state_log[67]}); else n_pass++;
   endtask

   task automatic test_narrow();
      logic [7:0] exp [0:5];
      acc_mem[0] = 32'd300;  acc_mem[1] = -32'sd200; acc_mem[2] = -32'sd1;
      acc_mem[3] = 32'd127;  acc_mem[4] = -32'sd128; acc_mem[5] = 32'd128;
`ifdef ACC_WB_SATURATE_EN
      exp = '{8'h7F, 8'h80, 8'hFF, 8'h7F, 8'h80, 8'h7F};
`else
      exp = '{8'h2C, 8'h38, 8'hFF, 8'h7F, 8'h80, 8'h80};
`endif
      run_pass(10'h000, -1, -1, -1);
      for (int k = 0; k < 6; k++) begin
         n_checks++; if (wr_data[k] !== exp[k]) $display("FAIL narrow[%0d] got=%h want=%h", k, wr_data[k], exp[k]); else n_pass++;
      end
   endtask

   task automatic test_addr_wrap();
      run_pass(10'h3F0, -1, -1, -1);
      n_checks++; if (wr_addr[15] !== 10'h3FF) $display("FAIL wrap_15 got=%h want=3ff", wr_addr[15]); else n_pass++;
      n_checks++; if (wr_addr[16] !== 10'h000) $display("FAIL wrap_16 got=%h want=000", wr_addr[16]); else n_pass++;
      n_checks++; if (wr_addr[63] !== 10'h02F) $display("FAIL wrap_63 got=%h want=02f", wr_addr[63]); else n_pass++;
   endtask

   task automatic test_abort();
      for (int k = 0; k < 64; k++) acc_mem[k] = 32'(3 * k);
      run_pass(10'h200, 10, -1, -1);
      n_checks++; if (nw !== 10) $display("FAIL abort_count got=%0d want=10", nw); else n_pass++;
      n_checks++; if (wr_addr[9] !== 10'h209 || wr_cyc[9] !== 11) $display("FAIL abort_last got=%h@%0d want=209@11", wr_addr[9], wr_cyc[9]); else n_pass++;
      n_checks++; if (state_log[12] !== 2'd0) $display("FAIL abort_idle got=%0d want=0", state_log[12]); else n_pass++;
      n_checks++; if (done_cnt !== 0) $display("FAIL abort_done got=%0d want=0", done_cnt); else n_pass++;
      run_pass(10'h040, -1, -1, -1);
      n_checks++; if (nw !== 64 || done_cyc !== 66) $display("FAIL abort_rerun got=%0d@%0d want=64@66", nw, done_cyc); else n_pass++;
   endtask

   task automatic test_back_to_back();
      run_pass(10'h080, -1, 20, -1);
      n_checks++; if (nw !== 64) $display("FAIL restart_count got=%0d want=64", nw); else n_pass++;
      n_checks++; if (done_cnt !== 1 || done_cyc !== 66) $display("FAIL restart_done got=%0d@%0d want=1@66", done_cnt, done_cyc); else n_pass++;
      n_checks++; if (wr_addr[63] !== 10'h0BF) $display("FAIL restart_last got=%h want=0bf", wr_addr[63]); else n_pass++;
      run_pass(10'h080, -1, -1, 30);
      n_checks++; if (snap !== 32'd0) $display("FAIL rst_outputs got=%h want=0", snap); else n_pass++;
      n_checks++; if (nw !== 30) $display("FAIL rst_count got=%0d want=30", nw); else n_pass++;
      n_checks++; if (done_cnt !== 0) $display("FAIL rst_done got=%0d want=0", done_cnt); else n_pass++;
      run_pass(10'h000, -1, -1, -1);
      n_checks++; if (nw !== 64 || done_cyc !== 66) $display("FAIL rst_rerun got=%0d@%0d want=64@66", nw, done_cyc); else n_pass++;
   endtask

   initial begin
      for (int k = 0; k < 64; k++) acc_mem[k] = '0;
      test_reset();
      test_full_pass();
      test_narrow();
      test_addr_wrap();
      test_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/acc_writeback_ctrl.md
ACC_WRITEBACK_CTRL -- requirements
Module: acc_writeback_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one DPRAM word and of the written-back value.
REQ-002 Parameter MATRIX_SIZE, default 8, systolic array dimension; N = MATRIX_SIZE*MATRIX_SIZE accumulators.
REQ-003 Parameter ACC_WIDTH, default 32, accumulator width.
REQ-004 Parameter ACC_ADDR_WIDTH, default $clog2(MATRIX_SIZE*MATRIX_SIZE), accumulator index width.
REQ-005 Parameter DP_ADDR_WIDTH, default 10, DPRAM address width.
REQ-006 Parameter SHIFT, default 0, arithmetic right-shift applied to each accumulator before narrowing.
REQ-007 clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 start  input  1  request one full writeback pass; sampled only in IDLE.
REQ-010 abort  input  1  terminate an active pass.
REQ-011 base_addr  input  DP_ADDR_WIDTH  DPRAM destination of accumulator 0; captured on start.
REQ-012 addr_acc  output  ACC_ADDR_WIDTH  accumulator index driven to the systolic module.
REQ-013 acc_out  input  ACC_WIDTH  accumulator value; valid one cycle after addr_acc is driven.
REQ-014 wb_we  output  1  DPRAM port write enable.
REQ-015 wb_addr  output  DP_ADDR_WIDTH  DPRAM write address.
REQ-016 wb_din  output  DATA_WIDTH  DPRAM write data.
REQ-017 busy  output  1  high from the cycle after start acceptance until return to IDLE.
REQ-018 done  output  1  one-cycle pulse on pass completion.
REQ-019 state_out  output  2  debug encoding of current state.

Function
REQ-020 States SHALL be IDLE=0, READ=1, DRAIN=2, FINISH=3, encoded on state_out.
REQ-021 IDLE: start=1 and abort=0 SHALL capture base_addr, clear index to 0, go READ; otherwise remain.
REQ-022 READ: addr_acc SHALL equal index k, k advancing by 1 per cycle from 0 to N-1; after k=N-1 go DRAIN.
REQ-023 In the cycle after addr_acc=k, wb_we SHALL be 1, wb_addr=(base+k) mod 2^DP_ADDR_WIDTH, wb_din=narrow(acc_out).
REQ-024 Exactly N writes SHALL occur per completed pass, one per cycle, no gaps; last write occurs in DRAIN.
REQ-025 DRAIN SHALL go FINISH; FINISH SHALL assert done for that single cycle and go IDLE.
REQ-026 Start-to-done latency SHALL be N+2 cycles after the accepting edge (N=64: done in cycle 66).
REQ-027 wb_we SHALL be 0 in every cycle not listed in REQ-023; addr_acc SHALL hold 0 outside READ.
REQ-028 narrow(x) = (x >>> SHIFT) reduced to DATA_WIDTH bits per REQ-036/037.
REQ-029 start while busy SHALL be ignored, with no effect on the active pass.
REQ-030 abort in READ or DRAIN SHALL go IDLE next edge; no write after the abort edge; done not asserted.
REQ-031 abort and start simultaneously in IDLE: abort wins, start ignored.
REQ-032 busy SHALL be 1 in READ, DRAIN, FINISH and 0 in IDLE.

Reset
REQ-033 rst=1 SHALL immediately force IDLE, index 0, captured base 0, all outputs 0, regardless of clk.
REQ-034 rst mid-pass SHALL abandon the pass with no further writes and no done pulse.
REQ-035 First start accepted on the first rising edge after rst deasserts.

Configuration
REQ-036 With ACC_WB_SATURATE_EN defined, narrow SHALL clamp the shifted signed value to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-037 Without ACC_WB_SATURATE_EN, narrow SHALL take the low DATA_WIDTH bits of the shifted value (wrap).

Verification
REQ-038 rst, then start with base=0x100, acc[k]=3k -> writes 0x100..0x13F with data 3k mod 256, done at cycle 66, busy low after.
REQ-039 acc[0]=300, acc[1]=-200, SHIFT=0 -> SATURATE_EN: 0x7F, 0x80; undefined: 0x2C, 0x38.
REQ-040 base=0x3F0 -> index 15 writes 0x3FF, index 16 writes 0x000, index 63 writes 0x02F.
REQ-041 abort during READ with addr_acc=10 -> write for index 9 is last, IDLE next cycle, no done; new start then runs full pass.
REQ-042 start pulsed at index 20 of active pass -> ignored, exactly 64 writes, one done; rst asserted at index 30 of next pass -> outputs 0 at once, no done.
